// File: rtl/flexka_recursion_ctrl_if.sv
// Bundle of command, status and stack-node signals for flexka_recursion_ctrl.
// The master modport is the sequencer's side. The slave modport is the side of
// the job source, the leaf/combine engines and the stack node.
// The stat_* signals exist only when FLEXKA_RCTRL_STATS_EN is defined.
interface flexka_recursion_ctrl_if #(
    parameter int SW = 16
);
    logic          start;
    logic [SW-1:0] job_size_a;
    logic [SW-1:0] job_size_b;
    logic          busy;
    logic          done;
    logic          error;
    logic          leaf_valid;
    logic          leaf_ready;
    logic [SW-1:0] leaf_size_a;
    logic [SW-1:0] leaf_size_b;
    logic          comb_valid;
    logic          comb_ready;
    logic [SW-1:0] comb_size_a;
    logic [SW-1:0] comb_size_b;
    logic          stk_push;
    logic          stk_pop;
    logic [SW-1:0] stk_size_a2;
    logic [SW-1:0] stk_size_b2;
    logic [SW-1:0] stk_top_a2;
    logic [SW-1:0] stk_top_b2;
    logic [SW-1:0] stk_depth;
`ifdef FLEXKA_RCTRL_STATS_EN
    logic [31:0]   stat_leaves;
    logic [SW-1:0] stat_max_depth;

    modport master (
        input  start, job_size_a, job_size_b, leaf_ready, comb_ready,
               stk_top_a2, stk_top_b2, stk_depth,
        output busy, done, error, leaf_valid, leaf_size_a, leaf_size_b,
               comb_valid, comb_size_a, comb_size_b, stk_push, stk_pop,
               stk_size_a2, stk_size_b2, stat_leaves, stat_max_depth
    );
    modport slave (
        output start, job_size_a, job_size_b, leaf_ready, comb_ready,
               stk_top_a2, stk_top_b2, stk_depth,
        input  busy, done, error, leaf_valid, leaf_size_a, leaf_size_b,
               comb_valid, comb_size_a, comb_size_b, stk_push, stk_pop,
               stk_size_a2, stk_size_b2, stat_leaves, stat_max_depth
    );
`else
    modport master (
        input  start, job_size_a, job_size_b, leaf_ready, comb_ready,
               stk_top_a2, stk_top_b2, stk_depth,
        output busy, done, error, leaf_valid, leaf_size_a, leaf_size_b,
               comb_valid, comb_size_a, comb_size_b, stk_push, stk_pop,
               stk_size_a2, stk_size_b2
    );
    modport slave (
        output start, job_size_a, job_size_b, leaf_ready, comb_ready,
               stk_top_a2, stk_top_b2, stk_depth,
        input  busy, done, error, leaf_valid, leaf_size_a, leaf_size_b,
               comb_valid, comb_size_a, comb_size_b, stk_push, stk_pop,
               stk_size_a2, stk_size_b2
    );
`endif
endinterface

// File: rtl/flexka_recursion_ctrl.sv
// Karatsuba recursion sequencer.
// Walks one job's recursion tree depth-first and emits leaf and combine
// commands. Parent frame sizes live in the external stack node. The child
// phase of each parent frame is kept locally in phase_stack_q, indexed by the
// stack depth.
// Optional statistics outputs are enabled by defining FLEXKA_RCTRL_STATS_EN.
module flexka_recursion_ctrl #(
    parameter int SW        = 16,
    parameter int BASE_SIZE = 4,
    parameter int MAX_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    flexka_recursion_ctrl_if.master        bus
);
    localparam int DW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, ROOTLEAF, EVAL, LEAF, PUSH, COMBINE, POP, RESTORE
    } state_t;

    state_t        state_q;
    logic [SW-1:0] cur_a_q, cur_b_q;
    logic [1:0]    phase_q;
    logic [1:0]    phase_stack_q [2**DW];
    logic          busy_q, done_q, error_q;
    logic          leaf_valid_q, comb_valid_q, stk_push_q, stk_pop_q;
    logic [SW-1:0] leaf_a_q, leaf_b_q, comb_a_q, comb_b_q;

    logic [SW-1:0] half_a, half_b, low_a, low_b;
    logic [SW-1:0] child_a, child_b;
    logic          child_zero, child_leaf, root_leaf;
    logic [DW-1:0] depth_idx;

    assign depth_idx = bus.stk_depth[DW-1:0];
    assign root_leaf = (bus.job_size_a <= SW'(BASE_SIZE)) &&
                       (bus.job_size_b <= SW'(BASE_SIZE));

    // Child sizes of the current frame for the current phase.
    always_comb begin
        half_a  = cur_a_q >> 1;
        half_b  = cur_b_q >> 1;
        low_a   = cur_a_q - half_a;
        low_b   = cur_b_q - half_b;
        child_a = '0;
        child_b = '0;
        unique case (phase_q)
            2'd0:    begin child_a = low_a;           child_b = low_b;           end
            2'd1:    begin child_a = half_a;          child_b = half_b;          end
            2'd2:    begin child_a = low_a + SW'(1);  child_b = low_b + SW'(1);  end
            default: begin child_a = '0;              child_b = '0;              end
        endcase
        child_zero = (child_a == '0) || (child_b == '0);
        child_leaf = (child_a <= SW'(BASE_SIZE)) && (child_b <= SW'(BASE_SIZE));
    end

    // Sequencer FSM. Every output is a register, loaded on the transition into
    // the state that presents it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cur_a_q      <= '0;
            cur_b_q      <= '0;
            phase_q      <= '0;
            // NOTE: phase_stack_q is cleared explicitly. An entry is only read
            // after it was written, but a defined reset image keeps
            // simulation and silicon identical after an aborted job.
            for (int i = 0; i < 2**DW; i++) phase_stack_q[i] <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            leaf_valid_q <= 1'b0;
            comb_valid_q <= 1'b0;
            stk_push_q   <= 1'b0;
            stk_pop_q    <= 1'b0;
            leaf_a_q     <= '0;
            leaf_b_q     <= '0;
            comb_a_q     <= '0;
            comb_b_q     <= '0;
        end else begin
            // NOTE: done_q defaults low every cycle, so each assignment of 1
            // below gives a single-cycle pulse.
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cur_a_q <= bus.job_size_a;
                        cur_b_q <= bus.job_size_b;
                        phase_q <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (root_leaf) begin
                            leaf_valid_q <= 1'b1;
                            leaf_a_q     <= bus.job_size_a;
                            leaf_b_q     <= bus.job_size_b;
                            state_q      <= ROOTLEAF;
                        end else begin
                            state_q <= EVAL;
                        end
                    end
                end
                ROOTLEAF: begin
                    if (bus.leaf_ready) begin
                        leaf_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                EVAL: begin
                    if (phase_q == 2'd3) begin
                        comb_valid_q <= 1'b1;
                        comb_a_q     <= cur_a_q;
                        comb_b_q     <= cur_b_q;
                        state_q      <= COMBINE;
                    end else if (child_zero) begin
                        // Empty high half (x = 1): nothing to compute.
                        phase_q <= phase_q + 2'd1;
                    end else if (child_leaf) begin
                        leaf_valid_q <= 1'b1;
                        leaf_a_q     <= child_a;
                        leaf_b_q     <= child_b;
                        state_q      <= LEAF;
                    end else begin
                        // Depth is stable until the push, so it is safe to
                        // decide the push here.
                        stk_push_q <= (bus.stk_depth != SW'(MAX_DEPTH));
                        state_q    <= PUSH;
                    end
                end
                LEAF: begin
                    if (bus.leaf_ready) begin
                        leaf_valid_q <= 1'b0;
                        phase_q      <= phase_q + 2'd1;
                        state_q      <= EVAL;
                    end
                end
                PUSH: begin
                    stk_push_q <= 1'b0;
                    if (!stk_push_q) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        phase_stack_q[depth_idx] <= phase_q;
                        cur_a_q <= child_a;
                        cur_b_q <= child_b;
                        phase_q <= '0;
                        state_q <= EVAL;
                    end
                end
                COMBINE: begin
                    if (bus.comb_ready) begin
                        comb_valid_q <= 1'b0;
                        if (bus.stk_depth == '0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            stk_pop_q <= 1'b1;
                            state_q   <= POP;
                        end
                    end
                end
                POP: begin
                    stk_pop_q <= 1'b0;
                    state_q   <= RESTORE;
                end
                RESTORE: begin
                    // The stack node has registered the parent sizes on the
                    // pop edge, and the depth now indexes the parent's phase.
                    cur_a_q <= bus.stk_top_a2;
                    cur_b_q <= bus.stk_top_b2;
                    phase_q <= phase_stack_q[depth_idx] + 2'd1;
                    state_q <= EVAL;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.leaf_valid  = leaf_valid_q;
    assign bus.leaf_size_a = leaf_a_q;
    assign bus.leaf_size_b = leaf_b_q;
    assign bus.comb_valid  = comb_valid_q;
    assign bus.comb_size_a = comb_a_q;
    assign bus.comb_size_b = comb_b_q;
    assign bus.stk_push    = stk_push_q;
    assign bus.stk_pop     = stk_pop_q;
    assign bus.stk_size_a2 = cur_a_q;
    assign bus.stk_size_b2 = cur_b_q;

`ifdef FLEXKA_RCTRL_STATS_EN
    logic [31:0]   stat_leaves_q;
    logic [SW-1:0] stat_max_depth_q;
    logic [SW-1:0] depth_after_push;

    assign depth_after_push = bus.stk_depth + SW'(1);

    // Job statistics: leaf handshakes and peak stack depth.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_leaves_q    <= '0;
            stat_max_depth_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            stat_leaves_q    <= '0;
            stat_max_depth_q <= '0;
        end else begin
            if (leaf_valid_q && bus.leaf_ready) stat_leaves_q <= stat_leaves_q + 32'd1;
            if (stk_push_q && depth_after_push > stat_max_depth_q)
                stat_max_depth_q <= depth_after_push;
        end
    end

    assign bus.stat_leaves    = stat_leaves_q;
    assign bus.stat_max_depth = stat_max_depth_q;
`endif
endmodule

// File: tb/tb_flexka_recursion_ctrl.sv
// Self-checking bench for flexka_recursion_ctrl. Each test queues the command
// sequence it expects, including pushes and pops. A monitor pops and compares
// one entry for every handshake or stack strobe it observes. Instance dut_lim
// runs with MAX_DEPTH = 1 to exercise the stack overflow path.
module tb_flexka_recursion_ctrl;
    localparam int SW = 16;

    typedef enum logic [1:0] {C_LEAF, C_COMB, C_PUSH, C_POP} kind_t;
    typedef struct packed {
        kind_t         kind;
        logic [SW-1:0] a;
        logic [SW-1:0] b;
    } cmd_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    cmd_t exp_q[$];
    int   done_cnt = 0, push_cnt = 0;
    int   done1_cnt = 0, push1_cnt = 0, pop1_cnt = 0, leaf1_cnt = 0, comb1_cnt = 0;
    logic [SW-1:0] push1_a, push1_b;

    flexka_recursion_ctrl_if #(.SW(SW)) bus0 ();
    flexka_recursion_ctrl_if #(.SW(SW)) bus1 ();

    flexka_recursion_ctrl #(.SW(SW), .BASE_SIZE(4), .MAX_DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .bus(bus0));
    flexka_recursion_ctrl #(.SW(SW), .BASE_SIZE(4), .MAX_DEPTH(1)) dut_lim (
        .clk(clk), .rstn(rstn), .bus(bus1));

    // Stack node models: write on push, register top on the pop edge.
    logic [SW-1:0] stk0_a [32], stk0_b [32], depth0;
    logic [SW-1:0] stk1_a [32], stk1_b [32], depth1;
    logic [SW-1:0] top0_a, top0_b, top1_a, top1_b;
    always @(posedge clk) begin
        if (!rstn) begin
            depth0 <= '0; top0_a <= '0; top0_b <= '0;
        end else if (bus0.stk_push) begin
            stk0_a[depth0[4:0]] <= bus0.stk_size_a2;
            stk0_b[depth0[4:0]] <= bus0.stk_size_b2;
            depth0 <= depth0 + 16'd1;
        end else if (bus0.stk_pop) begin
            top0_a <= stk0_a[depth0[4:0] - 5'd1];
            top0_b <= stk0_b[depth0[4:0] - 5'd1];
            depth0 <= depth0 - 16'd1;
        end
    end
    always @(posedge clk) begin
        if (!rstn) begin
            depth1 <= '0; top1_a <= '0; top1_b <= '0;
        end else if (bus1.stk_push) begin
            stk1_a[depth1[4:0]] <= bus1.stk_size_a2;
            stk1_b[depth1[4:0]] <= bus1.stk_size_b2;
            depth1 <= depth1 + 16'd1;
        end else if (bus1.stk_pop) begin
            top1_a <= stk1_a[depth1[4:0] - 5'd1];
            top1_b <= stk1_b[depth1[4:0] - 5'd1];
            depth1 <= depth1 - 16'd1;
        end
    end
    assign bus0.stk_depth  = depth0;
    assign bus0.stk_top_a2 = top0_a;
    assign bus0.stk_top_b2 = top0_b;
    assign bus1.stk_depth  = depth1;
    assign bus1.stk_top_a2 = top1_a;
    assign bus1.stk_top_b2 = top1_b;

    // Monitor for dut: scoreboard compare, exclusivity and stall stability.
    always @(negedge clk) begin : mon0
        cmd_t          obs, ecmd;
        bit            have;
        bit            hold_leaf, hold_comb;
        logic [SW-1:0] ha, hb;
        if (!rstn) begin
            hold_leaf = 1'b0;
            hold_comb = 1'b0;
        end else begin
            if (bus0.done) done_cnt++;
            checks++;
            if ((bus0.leaf_valid && bus0.comb_valid) || (bus0.stk_push && bus0.stk_pop)) begin
                failures++;
                $display("FAIL exclusive lv=%b cv=%b push=%b pop=%b required no overlap",
                         bus0.leaf_valid, bus0.comb_valid, bus0.stk_push, bus0.stk_pop);
            end
            if (hold_leaf) begin
                checks++;
                if (!bus0.leaf_valid || bus0.leaf_size_a !== ha || bus0.leaf_size_b !== hb) begin
                    failures++;
                    $display("FAIL leaf_stable got v=%b (%0d,%0d) required v=1 (%0d,%0d)",
                             bus0.leaf_valid, bus0.leaf_size_a, bus0.leaf_size_b, ha, hb);
                end
            end
            if (hold_comb) begin
                checks++;
                if (!bus0.comb_valid || bus0.comb_size_a !== ha || bus0.comb_size_b !== hb) begin
                    failures++;
                    $display("FAIL comb_stable got v=%b (%0d,%0d) required v=1 (%0d,%0d)",
                             bus0.comb_valid, bus0.comb_size_a, bus0.comb_size_b, ha, hb);
                end
            end
            hold_leaf = bus0.leaf_valid && !bus0.leaf_ready;
            hold_comb = bus0.comb_valid && !bus0.comb_ready;
            ha = hold_leaf ? bus0.leaf_size_a : bus0.comb_size_a;
            hb = hold_leaf ? bus0.leaf_size_b : bus0.comb_size_b;

            have = 1'b1;
            if (bus0.leaf_valid && bus0.leaf_ready)
                obs = '{kind: C_LEAF, a: bus0.leaf_size_a, b: bus0.leaf_size_b};
            else if (bus0.comb_valid && bus0.comb_ready)
                obs = '{kind: C_COMB, a: bus0.comb_size_a, b: bus0.comb_size_b};
            else if (bus0.stk_push) begin
                obs = '{kind: C_PUSH, a: bus0.stk_size_a2, b: bus0.stk_size_b2};
                push_cnt++;
            end else if (bus0.stk_pop)
                obs = '{kind: C_POP, a: '0, b: '0};
            else
                have = 1'b0;
            if (have) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL cmd_seq got kind=%0d (%0d,%0d) required nothing",
                             obs.kind, obs.a, obs.b);
                end else begin
                    ecmd = exp_q.pop_front();
                    if (obs !== ecmd) begin
                        failures++;
                        $display("FAIL cmd_seq got kind=%0d (%0d,%0d) required kind=%0d (%0d,%0d)",
                                 obs.kind, obs.a, obs.b, ecmd.kind, ecmd.a, ecmd.b);
                    end
                end
            end
        end
    end

    // Event counters for dut_lim.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus1.done) done1_cnt++;
            if (bus1.stk_push) begin
                push1_cnt++;
                push1_a = bus1.stk_size_a2;
                push1_b = bus1.stk_size_b2;
            end
            if (bus1.stk_pop) pop1_cnt++;
            if (bus1.leaf_valid && bus1.leaf_ready) leaf1_cnt++;
            if (bus1.comb_valid && bus1.comb_ready) comb1_cnt++;
        end
    end

    function automatic cmd_t mk(kind_t k, int a, int b);
        mk = '{kind: k, a: SW'(a), b: SW'(b)};
    endfunction

    task automatic queue_8x8();
        exp_q.push_back(mk(C_LEAF, 4, 4));
        exp_q.push_back(mk(C_LEAF, 4, 4));
        exp_q.push_back(mk(C_PUSH, 8, 8));
        exp_q.push_back(mk(C_LEAF, 3, 3));
        exp_q.push_back(mk(C_LEAF, 2, 2));
        exp_q.push_back(mk(C_LEAF, 4, 4));
        exp_q.push_back(mk(C_COMB, 5, 5));
        exp_q.push_back(mk(C_POP, 0, 0));
        exp_q.push_back(mk(C_COMB, 8, 8));
    endtask

    // Start a job on dut and run until its done pulse or the cycle budget expires.
    task automatic run_job(input int a, input int b, input bit rnd, input int budget,
                           output bit finished, output logic busy_seen, output int dones);
        int d0;
        d0 = done_cnt;
        @(posedge clk); #1;
        bus0.job_size_a = SW'(a);
        bus0.job_size_b = SW'(b);
        bus0.start      = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        busy_seen  = bus0.busy;
        finished   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            bus0.leaf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus0.comb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (done_cnt != d0) begin
                finished = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        dones = done_cnt - d0;
    endtask

    task automatic test_reset();
        logic [6*SW+6:0] outs0, outs1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outs0 = {bus0.busy, bus0.done, bus0.error, bus0.leaf_valid, bus0.comb_valid, bus0.stk_push,
                 bus0.stk_pop, bus0.leaf_size_a, bus0.leaf_size_b, bus0.comb_size_a,
                 bus0.comb_size_b, bus0.stk_size_a2, bus0.stk_size_b2};
        outs1 = {bus1.busy, bus1.done, bus1.error, bus1.leaf_valid, bus1.comb_valid, bus1.stk_push,
                 bus1.stk_pop, bus1.leaf_size_a, bus1.leaf_size_b, bus1.comb_size_a,
                 bus1.comb_size_b, bus1.stk_size_a2, bus1.stk_size_b2};
        checks++;
        if (outs0 !== '0 || outs1 !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h / %h required 0", outs0, outs1);
        end
        rstn = 1'b1;
    endtask

    task automatic check_job(input string name, input bit fin, input logic busy_seen,
                             input int dones, input int pushes);
        checks++;
        if (!fin || busy_seen !== 1'b1 || dones != 1) begin
            failures++;
            $display("FAIL %s_done got finished=%0d busy=%b dones=%0d required 1 1 1",
                     name, fin, busy_seen, dones);
        end
        checks++;
        if (exp_q.size() != 0 || bus0.busy !== 1'b0 || bus0.error !== 1'b0) begin
            failures++;
            $display("FAIL %s_end got left=%0d busy=%b error=%b required 0 0 0",
                     name, exp_q.size(), bus0.busy, bus0.error);
        end
        checks++;
        if (push_cnt != pushes || depth0 !== '0) begin
            failures++;
            $display("FAIL %s_stack got pushes=%0d depth=%0d required pushes=%0d depth=0",
                     name, push_cnt, depth0, pushes);
        end
        exp_q.delete();
    endtask

    task automatic test_root_leaf();
        bit fin; logic bs; int dn;
        push_cnt = 0;
        exp_q.push_back(mk(C_LEAF, 3, 4));
        run_job(3, 4, 1'b0, 50, fin, bs, dn);
        check_job("root_leaf", fin, bs, dn, 0);
`ifdef FLEXKA_RCTRL_STATS_EN
        checks++;
        if (bus0.stat_leaves !== 32'd1 || bus0.stat_max_depth !== '0) begin
            failures++;
            $display("FAIL root_leaf_stats got %0d,%0d required 1,0",
                     bus0.stat_leaves, bus0.stat_max_depth);
        end
`endif
    endtask

    task automatic test_8x8(input bit rnd, input string name);
        bit fin; logic bs; int dn;
        push_cnt = 0;
        queue_8x8();
        run_job(8, 8, rnd, 2000, fin, bs, dn);
        check_job(name, fin, bs, dn, 1);
`ifdef FLEXKA_RCTRL_STATS_EN
        checks++;
        if (bus0.stat_leaves !== 32'd5 || bus0.stat_max_depth !== SW'(1)) begin
            failures++;
            $display("FAIL %s_stats got %0d,%0d required 5,1",
                     name, bus0.stat_leaves, bus0.stat_max_depth);
        end
`endif
    endtask

    task automatic test_skip_high();
        bit fin; logic bs; int dn;
        push_cnt = 0;
        exp_q.push_back(mk(C_LEAF, 3, 1));
        exp_q.push_back(mk(C_LEAF, 4, 2));
        exp_q.push_back(mk(C_COMB, 5, 1));
        run_job(5, 1, 1'b0, 100, fin, bs, dn);
        check_job("skip_high", fin, bs, dn, 0);
    endtask

    task automatic test_depth_limit();
        bit fin;
        bus1.leaf_ready = 1'b1;
        bus1.comb_ready = 1'b1;
        @(posedge clk); #1;
        bus1.job_size_a = 16'd64;
        bus1.job_size_b = 16'd64;
        bus1.start      = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (!bus1.busy) begin
                fin = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!fin || bus1.error !== 1'b1 || done1_cnt != 0) begin
            failures++;
            $display("FAIL overflow got idle=%0d error=%b dones=%0d required 1 1 0",
                     fin, bus1.error, done1_cnt);
        end
        checks++;
        if (push1_cnt != 1 || push1_a !== 16'd64 || push1_b !== 16'd64 || pop1_cnt != 0 ||
            leaf1_cnt != 0 || comb1_cnt != 0) begin
            failures++;
            $display("FAIL overflow_cmds got push=%0d (%0d,%0d) pop=%0d leaf=%0d comb=%0d required 1 (64,64) 0 0 0",
                     push1_cnt, push1_a, push1_b, pop1_cnt, leaf1_cnt, comb1_cnt);
        end
        // The error flag clears when the next job is accepted.
        bus1.job_size_a = 16'd2;
        bus1.job_size_b = 16'd2;
        bus1.start      = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        checks++;
        if (bus1.error !== 1'b0 || bus1.busy !== 1'b1) begin
            failures++;
            $display("FAIL error_clear got error=%b busy=%b required 0 1", bus1.error, bus1.busy);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid_job();
        bit fin; logic [6*SW+6:0] outs;
        bus0.leaf_ready = 1'b0;
        bus0.comb_ready = 1'b0;
        @(posedge clk); #1;
        bus0.job_size_a = 16'd8;
        bus0.job_size_b = 16'd8;
        bus0.start      = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus0.leaf_valid) begin
                fin = 1'b1;
                break;
            end
        end
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL mid_job_leaf got leaf_valid=0 required 1");
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        outs = {bus0.busy, bus0.done, bus0.error, bus0.leaf_valid, bus0.comb_valid, bus0.stk_push,
                bus0.stk_pop, bus0.leaf_size_a, bus0.leaf_size_b, bus0.comb_size_a,
                bus0.comb_size_b, bus0.stk_size_a2, bus0.stk_size_b2};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL mid_job_reset got %h required 0", outs);
        end
        exp_q.delete();
        rstn = 1'b1;
        test_8x8(1'b0, "after_reset");
    endtask

    initial begin
        bus0.start = 1'b0; bus0.job_size_a = '0; bus0.job_size_b = '0;
        bus0.leaf_ready = 1'b0; bus0.comb_ready = 1'b0;
        bus1.start = 1'b0; bus1.job_size_a = '0; bus1.job_size_b = '0;
        bus1.leaf_ready = 1'b0; bus1.comb_ready = 1'b0;
        test_reset();
        test_root_leaf();
        test_8x8(1'b0, "job_8x8");
        test_8x8(1'b1, "random_ready");
        test_skip_high();
        test_depth_limit();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/flexka_recursion_ctrl.md
Name: flexka_recursion_ctrl

Overview:
- Karatsuba recursion sequencer; sits directly upstream of flexka_stack_local_node.
- Walks the recursion tree of one multiplication job of sizes (A, B) depth-first.
- Emits leaf (base multiply) commands and combine commands.
- Drives stk_push/stk_pop and the parent operand sizes into the stack node; restores them from the stack node on return.

Parameters:
- SW, 16: width of all operand-size fields; equals SSIZE of the stack node.
- BASE_SIZE, 4: a frame is a leaf when A <= BASE_SIZE and B <= BASE_SIZE; must be >= 3 so the mid term terminates.
- MAX_DEPTH, 16: push limit; must be <= STACK_BUFFER_SIZE.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  job request; accepted only in IDLE
- job_size_a / job_size_b  in  SW  root operand sizes; must be >= 1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the root combine or root leaf is accepted
- error  out  1  sticky overflow flag; cleared by reset or next accepted start
- leaf_valid / leaf_ready  out/in  1  leaf command handshake
- leaf_size_a / leaf_size_b  out  SW  leaf operand sizes
- comb_valid / comb_ready  out/in  1  combine command handshake
- comb_size_a / comb_size_b  out  SW  sizes of the frame being combined
- stk_push / stk_pop  out  1  to stack node push/pop
- stk_size_a2 / stk_size_b2  out  SW  to stack node in_size_A2/in_size_B2 (current frame sizes)
- stk_top_a2 / stk_top_b2  in  SW  from stack node size_A2/size_B2
- stk_depth  in  SW  from stack node depth

Behaviour:
- Reset values: all outputs 0. State IDLE; internal cur_a, cur_b, phase, and phase_stack cleared.
- Clock and reset: synchronous, active-low reset rstn; clock clk. Reset mid-job aborts immediately with no further handshakes; the stack node is reset by the same rstn.
- Child sizes of frame (a, b), where h = x>>1 and l = x-h:
  - phase 0 (low): (la, lb)
  - phase 1 (high): (ha, hb)
  - phase 2 (mid): (la+1, lb+1)
  - All arithmetic is SW bits. A child with size 0 in either operand (possible for high when x = 1) is skipped and phase increments.
- IDLE: on start, cur <= job sizes, phase <= 0, error <= 0. If the root is a leaf go to ROOTLEAF, else EVAL.
- ROOTLEAF: present the root sizes as a leaf. On leaf handshake, pulse done and go to IDLE.
- EVAL (1 cycle):
  - phase == 3 -> COMBINE.
  - Child of phase is a leaf -> LEAF.
  - Otherwise -> PUSH.
- LEAF: leaf_valid = 1 with the child sizes, held stable until leaf_ready. On handshake, phase++ and go to EVAL.
- PUSH (1 cycle):
  - If stk_depth == MAX_DEPTH: set error and go to IDLE; no push, no done.
  - Otherwise assert stk_push with stk_size = cur. Then phase_stack[stk_depth] <= phase, cur <= child, phase <= 0, and go to EVAL.
- COMBINE: comb_valid = 1 with cur sizes, held until comb_ready. On handshake:
  - If stk_depth == 0: pulse done and go to IDLE.
  - Otherwise go to POP.
- POP (1 cycle): assert stk_pop, then go to RESTORE.
- RESTORE (1 cycle):
  - stk_top is valid this cycle (the stack node registered it on the pop edge).
  - cur <= stk_top; phase <= phase_stack[stk_depth] + 1; go to EVAL.
- Handshake and stack rules:
  - leaf_valid and comb_valid are never asserted together.
  - stk_push and stk_pop are never asserted together; no push/pop outside PUSH/POP.
  - A pop never follows a push by fewer than 2 cycles; the EVAL/LEAF states guarantee this, and it satisfies the stack RAM read latency.
- start while busy is ignored.

Optional Feature:
- Macro: FLEXKA_RCTRL_STATS_EN.
- When defined, adds outputs stat_leaves (32b) and stat_max_depth (SW). Both clear on accepted start.
  - stat_leaves counts leaf handshakes, including ROOTLEAF.
  - stat_max_depth records the peak stk_depth after a push.
- When undefined, these ports and counters do not exist.

Test Plan:
- Reset, then start 3x4 with leaf_ready = 1 -> one leaf (3,4), no push/pop, done pulses; stk_depth stays 0.
- 8x8, ready always 1 -> leaves in order (4,4), (4,4), (3,3), (2,2), (4,4). One push (sizes 8,8), then combines (5,5) and (8,8). One pop, then done; stat_leaves = 5, stat_max_depth = 1.
- 8x8 with leaf_ready/comb_ready toggling randomly -> same command sequence; valid and sizes held stable while not ready.
- 5x1 -> leaves (3,1), then the high child (2,0) is skipped, then (4,2). Combine (5,1), done.
- 64x64 with MAX_DEPTH = 1 -> the second push attempt sets error, returns to IDLE, no done pulse.
- Reset asserted mid-job during LEAF -> next cycle all outputs 0, state IDLE. A new start 8x8 then completes correctly.
